// File: rtl/lcd_video_driver.sv
// Parametrised LCD raster driver: porch-programmable sync/DE timing, 13 test/stream
// display modes, and multi-pixel word unpacking from a show-ahead frame-buffer FIFO.
module lcd_video_driver #(
  parameter int H_SYNC          = 45,
  parameter int H_BACK          = 0,
  parameter int H_ACTIVE        = 480,
  parameter int H_FRONT         = 0,
  parameter int V_SYNC          = 16,
  parameter int V_BACK          = 0,
  parameter int V_ACTIVE        = 272,
  parameter int V_FRONT         = 0,
  parameter bit HS_POL          = 1'b0,
  parameter bit VS_POL          = 1'b0,
  parameter int COLOR_BITS      = 8,
  parameter int PIX_PER_WORD    = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MODE_RESET      = 0
) (
  input  logic                                   clk_lcd,
  input  logic                                   lcd_rst,
  input  logic                                   key1,
  input  logic [PIX_PER_WORD*3*COLOR_BITS-1:0]   lcd_data,
  input  logic                                   lcd_empty,
  output logic                                   lcd_rden,
  output logic                                   lcd_framesync,
  output logic                                   lcd_underflow,
  output logic [3:0]                             lcd_mode,
  output logic                                   lcd_dclk,
  output logic                                   lcd_hsync,
  output logic                                   lcd_vsync,
  output logic                                   lcd_de,
  output logic [COLOR_BITS-1:0]                  lcd_r,
  output logic [COLOR_BITS-1:0]                  lcd_g,
  output logic [COLOR_BITS-1:0]                  lcd_b
);

  typedef enum logic [3:0] {
    MODE_BLACK, MODE_WHITE, MODE_RED, MODE_GREEN, MODE_BLUE,
    MODE_GRID8, MODE_GRID32, MODE_HGREY, MODE_VGREY,
    MODE_HRED, MODE_HGREEN, MODE_HBLUE, MODE_STREAM
  } mode_e;

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int XW      = (COLOR_BITS > 6) ? COLOR_BITS : 6;
  localparam int YW      = (COLOR_BITS - 1 > 6) ? COLOR_BITS - 1 : 6;
  localparam int PW      = 3 * COLOR_BITS;
  localparam int LW      = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam int KW      = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ACT_BEG  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_ACT_END  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_BEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_ACT_END  = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [KW-1:0] KEY_SAT    = KW'(DEBOUNCE_CYCLES);
  localparam logic [KW-1:0] KEY_FIRE   = KW'(DEBOUNCE_CYCLES - 1);
  localparam logic [LW-1:0] LANE_LAST  = LW'(PIX_PER_WORD - 1);
  localparam mode_e         MODE_INIT  = mode_e'(4'(MODE_RESET));

  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [VW-1:0]         vcnt_q, vcnt_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [KW-1:0]         key_cnt_q, key_cnt_d;
  mode_e                 pending_q, pending_d, mode_q, mode_d;
  logic                  hs_q, vs_q, de_q, fs_q, uf_q, uf_d;
  logic [COLOR_BITS-1:0] r_q, g_q, b_q, r_d, g_d, b_d;

  logic          h_last, v_last, h_act, v_act, active, frame_start;
  logic          press, need_pix;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [PW-1:0] lane_pix;

  // Stage 0: raster counters, key debounce and mode bookkeeping.
  always_comb begin
    h_last      = (hcnt_q == H_LAST);
    v_last      = (vcnt_q == V_LAST);
    hcnt_d      = h_last ? '0 : hcnt_q + 1'b1;
    vcnt_d      = vcnt_q;
    if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;

    h_act       = (hcnt_q >= H_ACT_BEG) && (hcnt_q < H_ACT_END);
    v_act       = (vcnt_q >= V_ACT_BEG) && (vcnt_q < V_ACT_END);
    active      = h_act && v_act;
    frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    x           = XW'(hcnt_q - H_ACT_BEG);
    y           = YW'(vcnt_q - V_ACT_BEG);

    // Lane restarts every line; H_ACTIVE being a word multiple makes it wrap cleanly.
    lane_d      = h_act ? ((lane_q == LANE_LAST) ? '0 : lane_q + 1'b1) : '0;
    lane_pix    = lcd_data[(PIX_PER_WORD - 1 - int'(lane_q)) * PW +: PW];

    key_cnt_d   = key1 ? '0 : ((key_cnt_q == KEY_SAT) ? key_cnt_q : key_cnt_q + 1'b1);
    press       = !key1 && (key_cnt_q == KEY_FIRE);
    pending_d   = pending_q;
    if (press) pending_d = (pending_q == MODE_STREAM) ? MODE_BLACK : mode_e'(pending_q + 4'd1);

    // The old pending value is taken here, so a press on the frame-start cycle waits a frame.
    mode_d      = frame_start ? pending_q : mode_q;
    need_pix    = (mode_d == MODE_STREAM) && active;
    uf_d        = (need_pix && lcd_empty) || (uf_q && !frame_start);
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active) begin
      case (mode_d)
        MODE_WHITE:  begin r_d = '1; g_d = '1; b_d = '1; end
        MODE_RED:    r_d = '1;
        MODE_GREEN:  g_d = '1;
        MODE_BLUE:   b_d = '1;
        MODE_GRID8:  if (!(x[3] ^ y[3])) begin r_d = '1; g_d = '1; b_d = '1; end
        MODE_GRID32: if (!(x[5] ^ y[5])) begin r_d = '1; g_d = '1; b_d = '1; end
        MODE_HGREY:  begin
          r_d = x[COLOR_BITS-1:0];
          g_d = x[COLOR_BITS-1:0];
          b_d = x[COLOR_BITS-1:0];
        end
        MODE_VGREY:  begin
          r_d = {y[COLOR_BITS-2:0], 1'b0};
          g_d = {y[COLOR_BITS-2:0], 1'b0};
          b_d = {y[COLOR_BITS-2:0], 1'b0};
        end
        MODE_HRED:   r_d = x[COLOR_BITS-1:0];
        MODE_HGREEN: g_d = x[COLOR_BITS-1:0];
        MODE_HBLUE:  b_d = x[COLOR_BITS-1:0];
        MODE_STREAM: if (!lcd_empty) begin
          r_d = lane_pix[COLOR_BITS-1:0];
          g_d = lane_pix[2*COLOR_BITS-1:COLOR_BITS];
          b_d = lane_pix[3*COLOR_BITS-1:2*COLOR_BITS];
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_lcd) begin
    if (lcd_rst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      lane_q    <= '0;
      key_cnt_q <= '0;
      pending_q <= MODE_INIT;
      mode_q    <= MODE_INIT;
      hs_q      <= ~HS_POL;
      vs_q      <= ~VS_POL;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      uf_q      <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      lane_q    <= lane_d;
      key_cnt_q <= key_cnt_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      hs_q      <= (hcnt_q < H_SYNC_END) ? HS_POL : ~HS_POL;
      vs_q      <= (vcnt_q < V_SYNC_END) ? VS_POL : ~VS_POL;
      de_q      <= active;
      fs_q      <= frame_start;
      uf_q      <= uf_d;
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
    end
  end

  // Pop is combinational so the FIFO head advances right after its last lane is used.
  assign lcd_rden      = need_pix && (lane_q == LANE_LAST) && !lcd_empty && !lcd_rst;
  assign lcd_framesync = fs_q;
  assign lcd_underflow = uf_q;
  assign lcd_mode      = mode_q;
  assign lcd_dclk      = clk_lcd;
  assign lcd_hsync     = hs_q;
  assign lcd_vsync     = vs_q;
  assign lcd_de        = de_q;
  assign lcd_r         = r_q;
  assign lcd_g         = g_q;
  assign lcd_b         = b_q;

endmodule

// File: tb/tb_lcd_video_driver.sv
// Self-checking bench for lcd_video_driver: phase table plus a per-cycle scoreboard
// fed by a behavioural raster model, and hand sequences for press/reset corners.
module tb_lcd_video_driver;

  localparam int FRAME = 105;

  logic        clk_lcd = 1'b0;
  logic        lcd_rst, key1, lcd_empty;
  logic [95:0] lcd_data;
  logic        lcd_rden, lcd_framesync, lcd_underflow, lcd_dclk;
  logic        lcd_hsync, lcd_vsync, lcd_de;
  logic [3:0]  lcd_mode;
  logic [7:0]  lcd_r, lcd_g, lcd_b;

  logic        t_rden, t_fs, t_uf, t_dclk, t_hs, t_vs, t_de;
  logic [3:0]  t_mode;
  logic [7:0]  t_r, t_g, t_b;

  always #5 clk_lcd = ~clk_lcd;

  lcd_video_driver #(
    .H_SYNC(2), .H_BACK(3), .H_ACTIVE(8), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(8), .PIX_PER_WORD(4),
    .DEBOUNCE_CYCLES(4), .MODE_RESET(0)
  ) u_dut (
    .clk_lcd(clk_lcd), .lcd_rst(lcd_rst), .key1(key1), .lcd_data(lcd_data),
    .lcd_empty(lcd_empty), .lcd_rden(lcd_rden), .lcd_framesync(lcd_framesync),
    .lcd_underflow(lcd_underflow), .lcd_mode(lcd_mode), .lcd_dclk(lcd_dclk),
    .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync), .lcd_de(lcd_de),
    .lcd_r(lcd_r), .lcd_g(lcd_g), .lcd_b(lcd_b)
  );

  // Larger raster so the 8-pixel grid has an x=8 and y=8 to look at.
  lcd_video_driver #(
    .H_SYNC(2), .H_BACK(3), .H_ACTIVE(16), .H_FRONT(2),
    .V_SYNC(1), .V_BACK(1), .V_ACTIVE(16), .V_FRONT(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_BITS(8), .PIX_PER_WORD(4),
    .DEBOUNCE_CYCLES(4), .MODE_RESET(5)
  ) u_tall (
    .clk_lcd(clk_lcd), .lcd_rst(lcd_rst), .key1(1'b1), .lcd_data(96'h0),
    .lcd_empty(1'b1), .lcd_rden(t_rden), .lcd_framesync(t_fs),
    .lcd_underflow(t_uf), .lcd_mode(t_mode), .lcd_dclk(t_dclk),
    .lcd_hsync(t_hs), .lcd_vsync(t_vs), .lcd_de(t_de),
    .lcd_r(t_r), .lcd_g(t_g), .lcd_b(t_b)
  );

  typedef struct packed {
    logic       hs, vs, de, fs, uf;
    logic [3:0] mode;
    logic [7:0] r, g, b;
  } out_t;

  typedef struct {
    string name;
    int    frames;
    int    key_low;
    int    presses;
    int    empty_line;
    int    exp_mode;
    int    exp_pops;
    bit    exp_uf;
  } phase_t;

  int   tests = 0, fails = 0;
  out_t sb_q[$];
  int   m_h, m_v, m_kcnt, m_mode, m_pend, head, cyc;
  bit   m_uf;
  int   ph_hs, ph_vs, ph_de, ph_fs, ph_pops;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [23:0] pix(input int n, input int p);
    logic [7:0] r, g, b;
    r = 8'(n * 3 + p * 2 + 1);
    g = 8'(n * 5 + p * 3 + 16);
    b = 8'(n * 7 + p + 64);
    return {b, g, r};
  endfunction

  function automatic logic [95:0] make_word(input int n);
    logic [95:0] w;
    for (int p = 0; p < 4; p++) w[(3 - p) * 24 +: 24] = pix(n, p);
    return w;
  endfunction

  task automatic model_reset();
    m_h = 0; m_v = 0; m_kcnt = 0; m_mode = 0; m_pend = 0; m_uf = 1'b0; cyc = 0;
    sb_q.delete();
  endtask

  // One pixel clock: model the stage-0 cycle, check rden, then check the registered outputs.
  task automatic step(input logic k, input logic emp);
    out_t          e, got;
    int            x, y, cur, lane;
    bit            fs, act, exp_rd, ev, press, pop;
    logic [23:0]   px;
    key1      = k;
    lcd_empty = emp;
    lcd_data  = make_word(head);
    #1;
    fs   = (m_h == 0 && m_v == 0);
    cur  = fs ? m_pend : m_mode;
    act  = (m_h >= 5 && m_h < 13 && m_v >= 2 && m_v < 6);
    x    = m_h - 5;
    y    = m_v - 2;
    lane = act ? x % 4 : 0;
    e    = '0;
    e.hs = (m_h >= 2);
    e.vs = (m_v >= 1);
    e.de = act;
    e.fs = fs;
    if (act) begin
      case (cur)
        1:  {e.r, e.g, e.b} = {3{8'hff}};
        2:  e.r = 8'hff;
        3:  e.g = 8'hff;
        4:  e.b = 8'hff;
        5:  if ((((x >> 3) ^ (y >> 3)) & 1) == 0) {e.r, e.g, e.b} = {3{8'hff}};
        6:  if ((((x >> 5) ^ (y >> 5)) & 1) == 0) {e.r, e.g, e.b} = {3{8'hff}};
        7:  {e.r, e.g, e.b} = {3{8'(x)}};
        8:  {e.r, e.g, e.b} = {3{8'(y * 2)}};
        9:  e.r = 8'(x);
        10: e.g = 8'(x);
        11: e.b = 8'(x);
        12: if (!emp) begin
          px  = pix(head, lane);
          e.r = px[7:0];
          e.g = px[15:8];
          e.b = px[23:16];
        end
        default: ;
      endcase
    end
    exp_rd = (cur == 12) && act && (lane == 3) && !emp;
    ev     = (cur == 12) && act && emp;
    check("rden", 64'(lcd_rden), 64'(exp_rd));
    pop = lcd_rden;
    if (lcd_rden) ph_pops++;

    m_mode = cur;
    press  = !k && (m_kcnt == 3);
    m_kcnt = k ? 0 : ((m_kcnt < 4) ? m_kcnt + 1 : 4);
    if (press) m_pend = (m_pend + 1) % 13;
    m_uf   = ev ? 1'b1 : (fs ? 1'b0 : m_uf);
    e.mode = 4'(m_mode);
    e.uf   = m_uf;
    if (m_h == 14) begin
      m_h = 0;
      m_v = (m_v == 6) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    sb_q.push_back(e);

    @(posedge clk_lcd);
    #1;
    if (pop) head++;
    cyc++;
    got = {lcd_hsync, lcd_vsync, lcd_de, lcd_framesync, lcd_underflow, lcd_mode,
           lcd_r, lcd_g, lcd_b};
    e   = sb_q.pop_front();
    if (got !== e) $display("  at output cycle %0d", cyc);
    check("out", 64'(got), 64'(e));
    if (!lcd_hsync)   ph_hs++;
    if (!lcd_vsync)   ph_vs++;
    if (lcd_de)       ph_de++;
    if (lcd_framesync) ph_fs++;

    // Tall instance: output cycle n shows raster count n-1 (23 clocks per line).
    if (cyc == 52)  check("grid_x0_y0", {t_de, t_r, t_g, t_b}, {1'b1, 24'hffffff});
    if (cyc == 60)  check("grid_x8_y0", {t_de, t_r, t_g, t_b}, {1'b1, 24'h000000});
    if (cyc == 236) check("grid_x0_y8", {t_de, t_r, t_g, t_b}, {1'b1, 24'h000000});
    if (cyc == 244) check("grid_x8_y8", {t_de, t_r, t_g, t_b}, {1'b1, 24'hffffff});
  endtask

  task automatic check_reset_outputs(input string name);
    out_t got;
    got = {lcd_hsync, lcd_vsync, lcd_de, lcd_framesync, lcd_underflow, lcd_mode,
           lcd_r, lcd_g, lcd_b};
    check(name, 64'(got), 64'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 24'h0}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    phase_t tbl[19];
    bit     k, emp;
    int     ncyc;

    tbl[0]  = '{"mode0_2frames", 2, 0,  0,  -1, 0,  0,  1'b0};
    tbl[1]  = '{"short_press",   1, 3,  1,  -1, 0,  0,  1'b0};
    tbl[2]  = '{"long_press",    1, 20, 1,  -1, 0,  0,  1'b0};
    tbl[3]  = '{"white_11press", 1, 4,  11, -1, 1,  0,  1'b0};
    tbl[4]  = '{"stream",        2, 0,  0,  -1, 12, 16, 1'b0};
    tbl[5]  = '{"underflow",     1, 0,  0,  2,  12, 6,  1'b1};
    tbl[6]  = '{"uf_clear_wrap", 1, 4,  1,  -1, 12, 8,  1'b0};
    tbl[7]  = '{"press13",       1, 4,  13, -1, 0,  0,  1'b0};
    tbl[8]  = '{"after13",       1, 4,  5,  -1, 0,  0,  1'b0};
    tbl[9]  = '{"grid8",         1, 4,  2,  -1, 5,  0,  1'b0};
    tbl[10] = '{"hgrey",         1, 4,  1,  -1, 7,  0,  1'b0};
    tbl[11] = '{"vgrey",         1, 4,  1,  -1, 8,  0,  1'b0};
    tbl[12] = '{"hred",          1, 4,  1,  -1, 9,  0,  1'b0};
    tbl[13] = '{"hgreen",        1, 4,  1,  -1, 10, 0,  1'b0};
    tbl[14] = '{"hblue",         1, 4,  4,  -1, 11, 0,  1'b0};
    tbl[15] = '{"red",           1, 4,  1,  -1, 2,  0,  1'b0};
    tbl[16] = '{"green",         1, 4,  1,  -1, 3,  0,  1'b0};
    tbl[17] = '{"blue",          1, 4,  2,  -1, 4,  0,  1'b0};
    tbl[18] = '{"grid32",        1, 0,  0,  -1, 6,  0,  1'b0};

    lcd_rst   = 1'b1;
    key1      = 1'b1;
    lcd_empty = 1'b0;
    head      = 0;
    lcd_data  = make_word(0);
    repeat (3) @(posedge clk_lcd);
    #1;
    check_reset_outputs("reset_state");
    check("reset_rden", 64'(lcd_rden), 64'(0));
    check("tall_reset_mode", 64'(t_mode), 64'(5));
    lcd_rst = 1'b0;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      ph_hs = 0; ph_vs = 0; ph_de = 0; ph_fs = 0; ph_pops = 0;
      ncyc = tbl[i].frames * FRAME;
      for (int c = 0; c < ncyc; c++) begin
        k   = !(tbl[i].presses > 0 && c < tbl[i].presses * (tbl[i].key_low + 1) &&
                (c % (tbl[i].key_low + 1)) < tbl[i].key_low);
        emp = (m_v == tbl[i].empty_line);
        step(k, emp);
      end
      check({tbl[i].name, "_hsync"}, 64'(ph_hs), 64'(14 * tbl[i].frames));
      check({tbl[i].name, "_vsync"}, 64'(ph_vs), 64'(15 * tbl[i].frames));
      check({tbl[i].name, "_de"},    64'(ph_de), 64'(32 * tbl[i].frames));
      check({tbl[i].name, "_fsync"}, 64'(ph_fs), 64'(tbl[i].frames));
      check({tbl[i].name, "_pops"},  64'(ph_pops), 64'(tbl[i].exp_pops));
      check({tbl[i].name, "_mode"},  64'(lcd_mode), 64'(tbl[i].exp_mode));
      check({tbl[i].name, "_uf"},    64'(lcd_underflow), 64'(tbl[i].exp_uf));
    end

    // Press completing exactly on the frame-start cycle: applied one frame later.
    repeat (102) step(1'b1, 1'b0);
    repeat (4)   step(1'b0, 1'b0);
    check("fs_press_fsync", 64'(lcd_framesync), 64'(1));
    check("fs_press_mode_now", 64'(lcd_mode), 64'(6));
    repeat (104) step(1'b1, 1'b0);
    check("fs_press_mode_end", 64'(lcd_mode), 64'(6));
    step(1'b1, 1'b0);
    check("fs_press_mode_next", 64'(lcd_mode), 64'(7));

    // Mid-frame reset at hcnt=9, vcnt=3 for one clock.
    for (int i = 0; i < FRAME && !(m_h == 9 && m_v == 3); i++) step(1'b1, 1'b0);
    lcd_rst   = 1'b1;
    key1      = 1'b1;
    lcd_empty = 1'b0;
    #1;
    check("midrst_rden", 64'(lcd_rden), 64'(0));
    @(posedge clk_lcd);
    #1;
    check_reset_outputs("midrst_state");
    lcd_rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0);
    check("post_rst_fsync", 64'(lcd_framesync), 64'(1));
    ph_fs = 0;
    repeat (FRAME) step(1'b1, 1'b0);
    check("post_rst_frame_fsync", 64'(ph_fs), 64'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
